vga_vram_sched: RTL



---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_vram_sched.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA text controller: op codes, default geometry, scheduler states.
package vga_pkg;
  localparam logic [1:0] OP_NONE   = 2'd0;
  localparam logic [1:0] OP_CLEAR  = 2'd1;
  localparam logic [1:0] OP_SCROLL = 2'd2;

  localparam logic [7:0] RES_X_MAX_DEF = 8'd80;
  localparam logic [7:0] RES_Y_MAX_DEF = 8'd25;
  localparam logic [7:0] FILL_CHAR_DEF = 8'h20;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CLR      = 3'd1;
  localparam logic [2:0] ST_SCR_RD   = 3'd2;
  localparam logic [2:0] ST_SCR_WAIT = 3'd3;
  localparam logic [2:0] ST_SCR_WR   = 3'd4;
  localparam logic [2:0] ST_SCR_FILL = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;
endpackage

// File: rtl/vga_vram_sched.sv
// VRAM port scheduler: CPU writes take priority over a clear / scroll-up bulk engine.
// Scroll support is compiled in only when VGA_SCROLL_EN is defined.
module vga_vram_sched
  import vga_pkg::*;
#(
  parameter logic [7:0] RES_X_MAX = RES_X_MAX_DEF,
  parameter logic [7:0] RES_Y_MAX = RES_Y_MAX_DEF,
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_data,
  input  logic              i_op_start,
  input  logic [1:0]        i_op_code,
  output logic              o_op_busy,
  output logic              o_op_done,
  output logic [ADDR_W-1:0] o_vram_addr,
  output logic [7:0]        o_vram_data,
  output logic              o_vram_we,
  output logic [ADDR_W-1:0] o_vram_raddr,
  input  logic [7:0]        i_vram_rdata
);
  localparam logic [ADDR_W-1:0] N_CHARS = ADDR_W'(RES_X_MAX) * ADDR_W'(RES_Y_MAX);
  localparam logic [ADDR_W-1:0] ROW_W   = ADDR_W'(RES_X_MAX);
  localparam logic [ADDR_W-1:0] LAST    = N_CHARS - ADDR_W'(1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] a;

`ifdef VGA_SCROLL_EN
  localparam logic [ADDR_W-1:0] COPY_LAST = N_CHARS - ROW_W - ADDR_W'(1);
  logic [ADDR_W-1:0] raddr;
  logic [7:0]        cap;
  logic              cap_vld;
  logic [7:0]        copy_data;

  assign o_vram_raddr = raddr;
  // Read data is latched on the first SCR_WR edge so a CPU stall cannot disturb it.
  assign copy_data    = cap_vld ? cap : i_vram_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      raddr   <= '0;
      cap     <= '0;
      cap_vld <= 1'b0;
    end else if (state == ST_SCR_RD) begin
      raddr   <= a + ROW_W;
      cap_vld <= 1'b0;
    end else if (state == ST_SCR_WR && !cap_vld) begin
      cap     <= i_vram_rdata;
      cap_vld <= 1'b1;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^i_vram_rdata;
  assign o_vram_raddr = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      a           <= '0;
      o_op_busy   <= 1'b0;
      o_op_done   <= 1'b0;
      o_vram_we   <= 1'b0;
      o_vram_addr <= '0;
      o_vram_data <= '0;
    end else begin
      o_vram_we <= 1'b0;
      o_op_done <= 1'b0;
      // Any CPU strobe owns the port this cycle; the engine simply holds.
      if (i_cpu_we) begin
        o_vram_we   <= (i_cpu_addr < N_CHARS);
        o_vram_addr <= i_cpu_addr;
        o_vram_data <= i_cpu_data;
      end
      case (state)
        ST_IDLE: begin
          if (i_op_start && i_op_code == OP_CLEAR) begin
            state     <= ST_CLR;
            o_op_busy <= 1'b1;
            a         <= '0;
          end
`ifdef VGA_SCROLL_EN
          else if (i_op_start && i_op_code == OP_SCROLL) begin
            state     <= ST_SCR_RD;
            o_op_busy <= 1'b1;
            a         <= '0;
          end
`endif
        end
        ST_CLR, ST_SCR_FILL: begin
          if (!i_cpu_we) begin
            o_vram_we   <= 1'b1;
            o_vram_addr <= a;
            o_vram_data <= FILL_CHAR;
            if (a == LAST) begin
              state     <= ST_DONE;
              o_op_done <= 1'b1;
            end else begin
              a <= a + ADDR_W'(1);
            end
          end
        end
`ifdef VGA_SCROLL_EN
        ST_SCR_RD:   state <= ST_SCR_WAIT;
        ST_SCR_WAIT: state <= ST_SCR_WR;
        ST_SCR_WR: begin
          if (!i_cpu_we) begin
            o_vram_we   <= 1'b1;
            o_vram_addr <= a;
            o_vram_data <= copy_data;
            a           <= a + ADDR_W'(1);
            state       <= (a == COPY_LAST) ? ST_SCR_FILL : ST_SCR_RD;
          end
        end
`endif
        ST_DONE: begin
          state     <= ST_IDLE;
          o_op_busy <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          o_op_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
